byte_uart_tx: RTL
=================

BYTE_UART_TX -- requirements
Module: byte_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16: clock cycles per serial bit period, legal range 2..65535.
REQ-002 Parameter FIFO_DEPTH, default 8: byte FIFO entries, power of two, legal range 2..64.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 byte_in  input  8  byte from the 64-bit-to-byte serializer stage.
REQ-006 byte_valid  input  1  byte_in is valid this cycle; may stay high on consecutive cycles.
REQ-007 fifo_full  output  1  FIFO holds FIFO_DEPTH bytes; decoded from the registered count.
REQ-008 tx  output  1  serial line, 8N1, idle high, registered.
REQ-009 busy  output  1  high while the FIFO is non-empty or a frame is in progress.
REQ-010 overflow  output  1  one-cycle pulse; a byte was dropped on the previous edge.

Function
REQ-011 Write rule: byte_in is written at a rising edge iff byte_valid=1 and the pre-edge count < FIFO_DEPTH.
REQ-012 A write and a pop at the same edge are both performed, and count is unchanged.
REQ-013 Full rule: with byte_valid=1 and pre-edge count = FIFO_DEPTH, the byte is dropped even if a pop occurs at that edge.
REQ-014 A dropped byte sets overflow=1 for exactly the following cycle; N consecutive drops give N consecutive high cycles.
REQ-015 FIFO order is first-in first-out; read and write pointers wrap modulo FIFO_DEPTH.
REQ-016 Count width is clog2(FIFO_DEPTH)+1, so full and empty are distinguishable.
REQ-017 FSM states: IDLE, START, DATA, STOP.
REQ-018 IDLE: tx=1; at an edge with pre-edge count>0, pop the head into the shift register, clear the bit timer, go to START.
REQ-019 START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
REQ-020 DATA: tx = shift register LSB for CLKS_PER_BIT cycles per bit; LSB first; 8 bits; after bit 7, go to STOP.
REQ-021 STOP: tx=1 for CLKS_PER_BIT cycles.
REQ-022 End of STOP: if pre-edge count>0, pop and go directly to START (no extra idle bit); otherwise go to IDLE.
REQ-023 Frame length is exactly 10*CLKS_PER_BIT cycles, with no gaps between back-to-back frames.
REQ-024 Latency: a byte written at edge E into an empty FIFO while in IDLE drives tx low from edge E+1.
REQ-025 The bit timer counts 0..CLKS_PER_BIT-1 and wraps at each bit boundary; its width is clog2(CLKS_PER_BIT).
REQ-026 busy = (state != IDLE) or (count != 0).
REQ-027 byte_valid while busy is legal; the transmitter never stalls the upstream stage.

Reset
REQ-028 rst_n=0 forces immediately: state=IDLE, tx=1, count=0, both pointers=0, bit timer=0, bit index=0, shift register=0, overflow=0, busy=0, fifo_full=0.
REQ-029 Reset mid-frame aborts the frame; all queued bytes are discarded.
REQ-030 Reset release is synchronous-safe: the first write is accepted at the first rising edge with rst_n=1.
REQ-031 FIFO storage contents need no reset value.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=8)
REQ-032 Single byte 0xA5 at edge E.
- tx=0 during cycles E+1..E+4.
- Then bits 1,0,1,0,0,1,0,1, 4 cycles each.
- Then tx=1 (stop); busy falls after edge E+40.
REQ-033 Eight consecutive bytes 0x00..0x07.
- All accepted; overflow never asserts.
- 8 contiguous frames over 320 cycles, decoded in order 0x00..0x07.
REQ-034 Ten consecutive bytes 0x10..0x19.
- 9 accepted; 0x19 dropped.
- fifo_full=1 after the 9th write; one overflow pulse.
- Decoded output 0x10..0x18.
REQ-035 Simultaneous write and pop at the STOP-end edge with count=3: count stays 3 and the next frame starts with no gap.
REQ-036 rst_n low during DATA bit 3 with 4 bytes queued.
- tx=1, busy=0, fifo_full=0 immediately.
- After release, a new byte 0x3C transmits correctly with no stale data.

Source files
------------

// File: rtl/byte_uart_tx_if.sv
// Byte-stream handshake between the serializer stage and the UART transmitter.
interface byte_uart_tx_if;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       fifo_full;
    logic       tx;
    logic       busy;
    logic       overflow;

    modport master (
        output byte_in,
        output byte_valid,
        input  fifo_full,
        input  tx,
        input  busy,
        input  overflow
    );

    modport slave (
        input  byte_in,
        input  byte_valid,
        output fifo_full,
        output tx,
        output busy,
        output overflow
    );
endinterface

// File: rtl/byte_uart_tx.sv
// Byte FIFO feeding an 8N1 UART transmitter; back-to-back frames leave no idle gap.
module byte_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    byte_uart_tx_if.slave  bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [TW-1:0] TMAX_C  = TW'(CLKS_PER_BIT - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    logic [7:0]    mem_r [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [1:0]    state_r;
    logic [TW-1:0] timer_r;
    logic [2:0]    bit_idx_r;
    logic [7:0]    shift_r;
    logic          tx_r;
    logic          busy_r;
    logic          overflow_r;

    logic          wr_en_s;
    logic          drop_s;
    logic          pop_s;
    logic          bit_end_s;
    logic [1:0]    state_nxt_s;
    logic [TW-1:0] timer_nxt_s;
    logic [2:0]    bit_idx_nxt_s;
    logic [7:0]    shift_nxt_s;
    logic [CW-1:0] count_nxt_s;
    logic          tx_nxt_s;
    logic          busy_nxt_s;

    assign wr_en_s   = bus.byte_valid && (count_r != DEPTH_C);
    assign drop_s    = bus.byte_valid && (count_r == DEPTH_C);
    assign bit_end_s = (timer_r == TMAX_C);

    // Frame sequencer: bit timing, shifting and FIFO pops.
    always_comb begin
        state_nxt_s   = state_r;
        timer_nxt_s   = timer_r;
        bit_idx_nxt_s = bit_idx_r;
        shift_nxt_s   = shift_r;
        pop_s         = 1'b0;
        case (state_r)
            ST_IDLE: begin
                timer_nxt_s = TW'(0);
                if (count_r != CW'(0)) begin
                    pop_s       = 1'b1;
                    shift_nxt_s = mem_r[rd_ptr_r];
                    state_nxt_s = ST_START;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    timer_nxt_s   = TW'(0);
                    bit_idx_nxt_s = 3'd0;
                    state_nxt_s   = ST_DATA;
                end else begin
                    timer_nxt_s = timer_r + TW'(1);
                end
            end
            ST_DATA: begin
                if (bit_end_s) begin
                    timer_nxt_s = TW'(0);
                    shift_nxt_s = {1'b0, shift_r[7:1]};
                    if (bit_idx_r == 3'd7) begin
                        state_nxt_s = ST_STOP;
                    end else begin
                        bit_idx_nxt_s = bit_idx_r + 3'd1;
                    end
                end else begin
                    timer_nxt_s = timer_r + TW'(1);
                end
            end
            ST_STOP: begin
                if (bit_end_s) begin
                    timer_nxt_s = TW'(0);
                    // Chain straight into the next start bit when a byte is waiting.
                    if (count_r != CW'(0)) begin
                        pop_s       = 1'b1;
                        shift_nxt_s = mem_r[rd_ptr_r];
                        state_nxt_s = ST_START;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    timer_nxt_s = timer_r + TW'(1);
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                timer_nxt_s = TW'(0);
            end
        endcase
    end

    // Occupancy update and next values of the registered outputs.
    always_comb begin
        count_nxt_s = count_r;
        tx_nxt_s    = 1'b1;
        case ({wr_en_s, pop_s})
            2'b10:   count_nxt_s = count_r + CW'(1);
            2'b01:   count_nxt_s = count_r - CW'(1);
            default: count_nxt_s = count_r;
        endcase
        case (state_nxt_s)
            ST_IDLE:  tx_nxt_s = 1'b1;
            ST_START: tx_nxt_s = 1'b0;
            ST_DATA:  tx_nxt_s = shift_nxt_s[0];
            ST_STOP:  tx_nxt_s = 1'b1;
            default:  tx_nxt_s = 1'b1;
        endcase
        busy_nxt_s = (state_nxt_s != ST_IDLE) || (count_nxt_s != CW'(0));
    end

    // Control state, pointers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r   <= PW'(0);
            rd_ptr_r   <= PW'(0);
            count_r    <= CW'(0);
            state_r    <= ST_IDLE;
            timer_r    <= TW'(0);
            bit_idx_r  <= 3'd0;
            shift_r    <= 8'd0;
            tx_r       <= 1'b1;
            busy_r     <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            count_r    <= count_nxt_s;
            state_r    <= state_nxt_s;
            timer_r    <= timer_nxt_s;
            bit_idx_r  <= bit_idx_nxt_s;
            shift_r    <= shift_nxt_s;
            tx_r       <= tx_nxt_s;
            busy_r     <= busy_nxt_s;
            overflow_r <= drop_s;
        end
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= bus.byte_in;
        end
    end

    assign bus.fifo_full = (count_r == DEPTH_C);
    assign bus.tx        = tx_r;
    assign bus.busy      = busy_r;
    assign bus.overflow  = overflow_r;
endmodule
